// File: rtl/pcb_read_arbiter_pkg.sv
// Shared widths and address-field layout for the PCB read front-end.
package pcb_read_arbiter_pkg;

  localparam int unsigned PCB_ADDR_W = 16;
  localparam int unsigned PCB_DATA_W = 134;
  localparam int unsigned BUFID_W    = 9;
  localparam int unsigned LINE_W     = 7;

  // Read address layout: {bufid, line}
  localparam int unsigned ADDR_LINE_LSB  = 0;
  localparam int unsigned ADDR_LINE_MSB  = LINE_W - 1;
  localparam int unsigned ADDR_BUFID_LSB = LINE_W;
  localparam int unsigned ADDR_BUFID_MSB = PCB_ADDR_W - 1;

  typedef struct packed {
    logic [BUFID_W-1:0] bufid;
    logic [LINE_W-1:0]  line;
  } pcb_addr_t;

endpackage

// File: rtl/pcb_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// pointer; requesters acked in the current cycle are masked out.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask_ack,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     elig;
  int unsigned      idx;

  // Winner search starting at the pointer, wrapping N-1 to 0
  always_comb begin
    elig      = req & ~mask_ack;
    valid     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!valid && elig[IDX_W'(idx)]) begin
        valid     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    grant_onehot = valid ? (N'(1) << grant_idx) : '0;
  end

  // Pointer moves to the slot after the winner; idle cycles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pcb_read_arbiter.sv
// PCB read front-end: arbitrates port read requests onto the buffer RAM,
// routes returned lines to the requester, and arbitrates bufid releases
// onto the free list. Optional statistics counters: PCB_READ_STAT_EN.
module pcb_read_arbiter
  import pcb_read_arbiter_pkg::*;
#(
  parameter int unsigned PORT_NUM = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [PCB_ADDR_W*PORT_NUM-1:0] iv_pkt_raddr,
  input  logic [PORT_NUM-1:0]          i_pkt_rd,
  output logic [PORT_NUM-1:0]          o_pkt_raddr_ack,
  output logic [PCB_DATA_W-1:0]        ov_pkt_data,
  output logic [PORT_NUM-1:0]          o_pkt_data_wr,
  input  logic [BUFID_W*PORT_NUM-1:0]  iv_pkt_bufid,
  input  logic [PORT_NUM-1:0]          i_pkt_bufid_wr,
  output logic [PORT_NUM-1:0]          o_pkt_bufid_ack,
  output logic [PCB_ADDR_W-1:0]        ov_ram_raddr,
  output logic                         o_ram_rd,
  input  logic [PCB_DATA_W-1:0]        iv_ram_rdata,
  output logic [BUFID_W-1:0]           ov_free_bufid,
  output logic                         o_free_bufid_wr
`ifdef PCB_READ_STAT_EN
  ,
  input  logic                         i_stat_clr,
  output logic [31:0]                  ov_rd_cnt,
  output logic [31:0]                  ov_rel_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(PORT_NUM);
  localparam int unsigned PIPE_W = RD_LAT * IDX_W;

  logic [PORT_NUM-1:0] rd_onehot;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_valid;
  logic [PORT_NUM-1:0] rel_onehot;
  logic [IDX_W-1:0]    rel_idx;
  logic                rel_valid;
  pcb_addr_t           sel_raddr;
  logic [BUFID_W-1:0]  sel_bufid;

  logic [IDX_W-1:0]    rd_id;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [PIPE_W-1:0]   pipe_id;
  logic [IDX_W-1:0]    tail_id;

  rr_arbiter #(.N(PORT_NUM)) u_rd_arb (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .req          (i_pkt_rd),
    .mask_ack     (o_pkt_raddr_ack),
    .grant_onehot (rd_onehot),
    .grant_idx    (rd_idx),
    .valid        (rd_valid)
  );

  rr_arbiter #(.N(PORT_NUM)) u_rel_arb (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .req          (i_pkt_bufid_wr),
    .mask_ack     (o_pkt_bufid_ack),
    .grant_onehot (rel_onehot),
    .grant_idx    (rel_idx),
    .valid        (rel_valid)
  );

  // Select the winning port's read address and release bufid
  always_comb begin
    sel_raddr = '0;
    sel_bufid = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (32'(rd_idx) == p)
        sel_raddr = iv_pkt_raddr[p*PCB_ADDR_W +: PCB_ADDR_W];
      if (32'(rel_idx) == p)
        sel_bufid = iv_pkt_bufid[p*BUFID_W +: BUFID_W];
    end
  end

  // Read grant register: ack pulse, RAM strobe, address held when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_raddr_ack <= '0;
      ov_ram_raddr    <= '0;
      o_ram_rd        <= 1'b0;
      rd_id           <= '0;
    end else begin
      o_pkt_raddr_ack <= rd_onehot;
      o_ram_rd        <= rd_valid;
      if (rd_valid) begin
        ov_ram_raddr <= sel_raddr;
        rd_id        <= rd_idx;
      end
    end
  end

  // Flat shift registers keep RD_LAT=1 legal; the tail lines up with RAM data
  assign tail_id = pipe_id[PIPE_W-1 -: IDX_W];

  // Return pipeline and registered data delivery
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld      <= '0;
      pipe_id       <= '0;
      o_pkt_data_wr <= '0;
      ov_pkt_data   <= '0;
    end else begin
      pipe_vld      <= (pipe_vld << 1) | RD_LAT'(o_ram_rd);
      pipe_id       <= (pipe_id << IDX_W) | PIPE_W'(rd_id);
      o_pkt_data_wr <= pipe_vld[RD_LAT-1] ? (PORT_NUM'(1) << tail_id) : '0;
      if (pipe_vld[RD_LAT-1])
        ov_pkt_data <= iv_ram_rdata;
    end
  end

  // Release grant register: ack pulse and free-list write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_bufid_ack <= '0;
      ov_free_bufid   <= '0;
      o_free_bufid_wr <= 1'b0;
    end else begin
      o_pkt_bufid_ack <= rel_onehot;
      o_free_bufid_wr <= rel_valid;
      if (rel_valid)
        ov_free_bufid <= sel_bufid;
    end
  end

`ifdef PCB_READ_STAT_EN
  // Read/release event counters; clear wins over a same-cycle increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_rd_cnt  <= '0;
      ov_rel_cnt <= '0;
    end else if (i_stat_clr) begin
      ov_rd_cnt  <= '0;
      ov_rel_cnt <= '0;
    end else begin
      ov_rd_cnt  <= ov_rd_cnt + 32'(o_ram_rd);
      ov_rel_cnt <= ov_rel_cnt + 32'(o_free_bufid_wr);
    end
  end
`endif

endmodule

// File: tb/tb_pcb_read_arbiter.sv
// Directed bench for pcb_read_arbiter (PORT_NUM=4, RD_LAT=2) with a
// two-stage synchronous RAM model.
module tb_pcb_read_arbiter;

  logic         clk;
  logic         rst_n;
  logic [63:0]  raddr_bus;
  logic [3:0]   pkt_rd;
  logic [3:0]   raddr_ack;
  logic [133:0] pkt_data;
  logic [3:0]   data_wr;
  logic [35:0]  bufid_bus;
  logic [3:0]   bufid_wr;
  logic [3:0]   bufid_ack;
  logic [15:0]  ram_raddr;
  logic         ram_rd;
  logic [133:0] ram_rdata;
  logic [133:0] ram_s1;
  logic [8:0]   free_bufid;
  logic         free_wr;
`ifdef PCB_READ_STAT_EN
  logic         stat_clr;
  logic [31:0]  rd_cnt;
  logic [31:0]  rel_cnt;
`endif

  int n_checks;
  int n_fail;

  pcb_read_arbiter #(.PORT_NUM(4), .RD_LAT(2)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .iv_pkt_raddr    (raddr_bus),
    .i_pkt_rd        (pkt_rd),
    .o_pkt_raddr_ack (raddr_ack),
    .ov_pkt_data     (pkt_data),
    .o_pkt_data_wr   (data_wr),
    .iv_pkt_bufid    (bufid_bus),
    .i_pkt_bufid_wr  (bufid_wr),
    .o_pkt_bufid_ack (bufid_ack),
    .ov_ram_raddr    (ram_raddr),
    .o_ram_rd        (ram_rd),
    .iv_ram_rdata    (ram_rdata),
    .ov_free_bufid   (free_bufid),
    .o_free_bufid_wr (free_wr)
`ifdef PCB_READ_STAT_EN
    ,
    .i_stat_clr      (stat_clr),
    .ov_rd_cnt       (rd_cnt),
    .ov_rel_cnt      (rel_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] ram_word(input logic [15:0] a);
    return {6'h15, 64'hC0DE_5EED_0000_0000, 32'h0, ~a, a};
  endfunction

  function automatic logic [15:0] addr_of(input int p);
    return 16'(16'h1000 + p * 16'h0111);
  endfunction

  // RAM model: address sampled with the strobe, data valid RD_LAT=2 cycles later
  always @(posedge clk) begin
    ram_s1    <= ram_rd ? ram_word(ram_raddr) : '0;
    ram_rdata <= ram_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pkt_rd    = '0;
    bufid_wr  = '0;
    raddr_bus = '0;
    bufid_bus = '0;
`ifdef PCB_READ_STAT_EN
    stat_clr  = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ram_s1    = '0;
    ram_rdata = '0;
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({raddr_ack, data_wr, bufid_ack} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_acks: got %h expected 000", {raddr_ack, data_wr, bufid_ack});
    end
    n_checks++;
    if ({ram_rd, free_wr} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00", {ram_rd, free_wr});
    end
    n_checks++;
    if (ram_raddr !== 16'h0 || free_bufid !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_addr: raddr %h bufid %h expected 0", ram_raddr, free_bufid);
    end
    n_checks++;
    if (pkt_data !== 134'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", pkt_data);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    raddr_bus[16 +: 16] = 16'h0A05;
    pkt_rd = 4'b0010;
    tick(); // cycle 1
    n_checks++;
    if (raddr_ack !== 4'b0010 || ram_rd !== 1'b1 || ram_raddr !== 16'h0A05) begin
      n_fail++;
      $display("FAIL single_grant: ack %b rd %b addr %h expected 0010 1 0a05", raddr_ack, ram_rd, ram_raddr);
    end
    pkt_rd = '0;
    tick(); // cycle 2
    n_checks++;
    if (raddr_ack !== 4'b0000 || ram_rd !== 1'b0 || ram_raddr !== 16'h0A05) begin
      n_fail++;
      $display("FAIL single_idle: ack %b rd %b addr %h expected 0000 0 0a05", raddr_ack, ram_rd, ram_raddr);
    end
    tick(); // cycle 3
    n_checks++;
    if (data_wr !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_early: data_wr %b expected 0000", data_wr);
    end
    tick(); // cycle 4
    n_checks++;
    if (data_wr !== 4'b0010 || pkt_data !== ram_word(16'h0A05)) begin
      n_fail++;
      $display("FAIL single_return: data_wr %b data %h expected 0010 %h", data_wr, pkt_data, ram_word(16'h0A05));
    end
    tick(); // cycle 5
    n_checks++;
    if (data_wr !== 4'b0000 || pkt_data !== ram_word(16'h0A05)) begin
      n_fail++;
      $display("FAIL single_hold: data_wr %b data %h expected 0000 held", data_wr, pkt_data);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ack;
    logic [3:0] exp_wr;
    do_reset();
    for (int p = 0; p < 4; p++) raddr_bus[p*16 +: 16] = addr_of(p);
    pkt_rd = 4'b1111;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_ack = (i <= 8) ? 4'(1 << ((i - 1) % 4)) : 4'b0000;
      exp_wr  = (i >= 4 && i <= 11) ? 4'(1 << ((i - 4) % 4)) : 4'b0000;
      n_checks++;
      if (raddr_ack !== exp_ack || ram_rd !== (i <= 8)) begin
        n_fail++;
        $display("FAIL fair_ack cyc %0d: ack %b rd %b expected %b", i, raddr_ack, ram_rd, exp_ack);
      end
      if (i <= 8) begin
        n_checks++;
        if (ram_raddr !== addr_of((i - 1) % 4)) begin
          n_fail++;
          $display("FAIL fair_addr cyc %0d: got %h expected %h", i, ram_raddr, addr_of((i - 1) % 4));
        end
      end
      n_checks++;
      if (data_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL fair_wr cyc %0d: got %b expected %b", i, data_wr, exp_wr);
      end
      if (i >= 4 && i <= 11) begin
        n_checks++;
        if (pkt_data !== ram_word(addr_of((i - 4) % 4))) begin
          n_fail++;
          $display("FAIL fair_data cyc %0d: got %h expected %h", i, pkt_data, ram_word(addr_of((i - 4) % 4)));
        end
      end
      if (i == 8) pkt_rd = '0;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b1000;
    do_reset();
    for (int p = 0; p < 4; p++) raddr_bus[p*16 +: 16] = addr_of(p);
    pkt_rd = 4'b0100; // moves the pointer to 3
    tick();
    n_checks++;
    if (raddr_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_setup: ack %b expected 0100", raddr_ack);
    end
    pkt_rd = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (raddr_ack !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL wrap_grant %0d: ack %b expected %b", i, raddr_ack, exp_seq[i]);
      end
    end
    pkt_rd = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_release_concurrent();
    do_reset();
    raddr_bus[32 +: 16] = 16'h1234;
    bufid_bus[18 +: 9]  = 9'h1FF;
    pkt_rd   = 4'b0100;
    bufid_wr = 4'b0100;
    tick();
    n_checks++;
    if (raddr_ack !== 4'b0100 || bufid_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL rel_acks: rd_ack %b rel_ack %b expected 0100 0100", raddr_ack, bufid_ack);
    end
    n_checks++;
    if (free_wr !== 1'b1 || free_bufid !== 9'h1FF || ram_raddr !== 16'h1234) begin
      n_fail++;
      $display("FAIL rel_free: wr %b bufid %h raddr %h expected 1 1ff 1234", free_wr, free_bufid, ram_raddr);
    end
    pkt_rd   = '0;
    bufid_wr = '0;
    tick();
    n_checks++;
    if (free_wr !== 1'b0 || free_bufid !== 9'h1FF || bufid_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL rel_idle: wr %b bufid %h ack %b expected 0 1ff 0000", free_wr, free_bufid, bufid_ack);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    raddr_bus[0 +: 16] = 16'h0BEE;
    pkt_rd = 4'b0001;
    tick(); // grant
    pkt_rd = '0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({raddr_ack, data_wr, bufid_ack, ram_rd, free_wr} !== 14'h0 || ram_raddr !== 16'h0) begin
      n_fail++;
      $display("FAIL midflight_reset: flags %h raddr %h expected 0", {raddr_ack, data_wr, bufid_ack, ram_rd, free_wr}, ram_raddr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (data_wr !== 4'b0000) begin
        n_fail++;
        $display("FAIL midflight_return %0d: data_wr %b expected 0000", i, data_wr);
      end
    end
  endtask

`ifdef PCB_READ_STAT_EN
  task automatic test_stat();
    do_reset();
    for (int p = 0; p < 4; p++) raddr_bus[p*16 +: 16] = addr_of(p);
    bufid_bus[27 +: 9] = 9'h0A3;
    pkt_rd = 4'b0011;
    for (int i = 0; i < 10; i++) tick();
    pkt_rd = '0;
    for (int i = 0; i < 3; i++) begin
      bufid_wr = 4'b1000;
      tick();
      bufid_wr = '0;
      tick();
    end
    tick();
    n_checks++;
    if (rd_cnt !== 32'd10 || rel_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL stat_count: rd %0d rel %0d expected 10 3", rd_cnt, rel_cnt);
    end
    stat_clr = 1'b1;
    pkt_rd   = 4'b0001;
    tick();
    pkt_rd = '0;
    n_checks++;
    if (rd_cnt !== 32'd0 || ram_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL stat_clr: rd %0d ram_rd %b expected 0 1", rd_cnt, ram_rd);
    end
    tick();
    stat_clr = 1'b0;
    n_checks++;
    if (rd_cnt !== 32'd0 || rel_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_clr_prio: rd %0d rel %0d expected 0 0", rd_cnt, rel_cnt);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_read();
    test_fairness();
    test_wrap();
    test_release_concurrent();
    test_reset_midflight();
`ifdef PCB_READ_STAT_EN
    test_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
